// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl
//   Controls the stall and flush inputs of the rename-to-dispatch (RO_DP)
//   pipeline register. It routes the held instruction to the reservation
//   station (RS) for its functional-unit type. Per-FU credit counters track
//   free RS slots. The register is held while the target RS has no free slot.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   flush          pipeline flush from commit (mispredict / exception)
//   valid_RN       rename stage presents an instruction this cycle
//   FUType_DP      FU type of the instruction held in RO_DP (0 = bubble)
//   rs_release     per-FU pulse: that RS freed one entry this cycle
//   stall_RO_DP    hold RO_DP contents
//   flush_RO_DP    insert a bubble into RO_DP
//   stall_RN       back-pressure to rename
//   dispatch_valid the RO_DP instruction is written to an RS this cycle
//   dispatch_sel   one-hot RS write enable
//   credit         packed credit counters, FU i at [i*CW +: CW]
//   stall_cycles   free-running count of stalled cycles (wraps)
//   err            sticky error: illegal FU type or credit overflow
//
// RO_DP occupancy states
//   state    | meaning
//   DP_EMPTY | RO_DP holds no valid instruction; all controls idle
//   DP_FULL  | RO_DP holds an instruction waiting to dispatch or retire as bubble

module dispatch_credit_ctrl #(
  parameter int NUM_FU   = 4,
  parameter int RS_DEPTH = 4,
  localparam int CW      = $clog2(RS_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valid_RN,
  input  logic [2:0]           FUType_DP,
  input  logic [NUM_FU-1:0]    rs_release,
  output logic                 stall_RO_DP,
  output logic                 flush_RO_DP,
  output logic                 stall_RN,
  output logic                 dispatch_valid,
  output logic [NUM_FU-1:0]    dispatch_sel,
  output logic [NUM_FU*CW-1:0] credit,
  output logic [31:0]          stall_cycles,
  output logic                 err
);

  localparam logic [CW-1:0] CRED_MAX = CW'(RS_DEPTH);

  typedef enum logic {DP_EMPTY = 1'b0, DP_FULL = 1'b1} dp_state_t;

  dp_state_t           dp_state;
  logic                valid_dp;
  logic [CW-1:0]       credit_q [NUM_FU];

  logic                legal;
  logic                illegal;
  logic [NUM_FU-1:0]   tgt;        // one-hot target RS, zero when fu is not legal
  logic [NUM_FU-1:0]   cred_zero;
  logic                tgt_full;
  logic                can_dispatch;
  logic [NUM_FU-1:0]   ovf;        // release arriving at an already-full counter

  assign valid_dp = (dp_state == DP_FULL);

  // Decode
  always_comb begin
    legal   = (FUType_DP >= 3'd1) && (FUType_DP <= 3'(NUM_FU));
    illegal = valid_dp && (FUType_DP > 3'(NUM_FU));
    tgt       = '0;
    cred_zero = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      tgt[i]       = legal && (FUType_DP == 3'(i + 1));
      cred_zero[i] = (credit_q[i] == '0);
    end
    tgt_full = |(tgt & cred_zero);
  end

  // Control outputs. Flush has to mask stall because RO_DP itself gives
  // stall priority over flush; otherwise a flushed, blocked instruction
  // would survive the flush.
  always_comb begin
    can_dispatch   = valid_dp && legal && !tgt_full;
    dispatch_valid = can_dispatch && !flush;
    dispatch_sel   = dispatch_valid ? tgt : '0;
    stall_RO_DP    = valid_dp && legal && tgt_full && !flush;
    stall_RN       = stall_RO_DP;
    flush_RO_DP    = flush;
  end

  always_comb begin
    ovf = '0;
    for (int i = 0; i < NUM_FU; i++)
      ovf[i] = !flush && rs_release[i] && !dispatch_sel[i] && (credit_q[i] == CRED_MAX);
  end

  always_comb begin
    credit = '0;
    for (int i = 0; i < NUM_FU; i++)
      credit[i*CW +: CW] = credit_q[i];
  end

  // Occupancy, stall counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state     <= DP_EMPTY;
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      if (flush)
        dp_state <= DP_EMPTY;
      else if (!stall_RO_DP)
        dp_state <= valid_RN ? DP_FULL : DP_EMPTY;

      if (stall_RO_DP)
        stall_cycles <= stall_cycles + 32'd1;

      if (illegal || (|ovf))
        err <= 1'b1;
    end
  end

  // Credit counters. The RSs are emptied by a flush, so every counter
  // reloads to full and any release in that cycle is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++)
        credit_q[i] <= CRED_MAX;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++)
        credit_q[i] <= CRED_MAX;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (rs_release[i] && !dispatch_sel[i]) begin
          if (credit_q[i] != CRED_MAX)
            credit_q[i] <= credit_q[i] + CW'(1);
        end else if (!rs_release[i] && dispatch_sel[i]) begin
          credit_q[i] <= credit_q[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
module tb_dispatch_credit_ctrl;

  localparam int NUM_FU   = 4;
  localparam int RS_DEPTH = 4;
  localparam int CW       = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 valid_RN;
  logic [2:0]           FUType_DP;
  logic [NUM_FU-1:0]    rs_release;
  logic                 stall_RO_DP;
  logic                 flush_RO_DP;
  logic                 stall_RN;
  logic                 dispatch_valid;
  logic [NUM_FU-1:0]    dispatch_sel;
  logic [NUM_FU*CW-1:0] credit;
  logic [31:0]          stall_cycles;
  logic                 err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] CRED_ALL4 = 32'h924;

  dispatch_credit_ctrl #(.NUM_FU(NUM_FU), .RS_DEPTH(RS_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .valid_RN       (valid_RN),
    .FUType_DP      (FUType_DP),
    .rs_release     (rs_release),
    .stall_RO_DP    (stall_RO_DP),
    .flush_RO_DP    (flush_RO_DP),
    .stall_RN       (stall_RN),
    .dispatch_valid (dispatch_valid),
    .dispatch_sel   (dispatch_sel),
    .credit         (credit),
    .stall_cycles   (stall_cycles),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic cyc(input logic vrn, input logic [2:0] fu,
                     input logic [NUM_FU-1:0] rel, input logic fl);
    @(posedge clk);
    #1;
    valid_RN   = vrn;
    FUType_DP  = fu;
    rs_release = rel;
    flush      = fl;
    #2;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b1; valid_RN = 0; FUType_DP = 0; rs_release = 0; flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 0; valid_RN = 0; FUType_DP = 0; rs_release = 0;
    #2;
    chk("rst_credit", 32'(credit), CRED_ALL4);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dispatch", 32'(dispatch_valid), 32'd0);
    #1 rst = 1'b0;

    // Four FU1 instructions back to back, then a fifth that stalls
    cyc(1, 3'd0, 4'b0, 0);
    chk("idle_sel", 32'(dispatch_sel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 3'd1, 4'b0, 0);
      chk($sformatf("fu1_sel_%0d", k), 32'(dispatch_sel), 32'b0001);
      chk($sformatf("fu1_cred_%0d", k), 32'(credit[2:0]), 32'(4 - k));
    end
    cyc(1, 3'd1, 4'b0, 0);
    chk("c0_zero", 32'(credit[2:0]), 32'd0);
    chk("stall_ro", 32'(stall_RO_DP), 32'd1);
    chk("stall_rn", 32'(stall_RN), 32'd1);
    chk("stall_nodisp", 32'(dispatch_valid), 32'd0);
    cyc(1, 3'd1, 4'b0, 0);
    chk("stall_cnt1", stall_cycles, 32'd1);

    // Release one FU1 slot: no same-cycle bypass, dispatch next cycle
    cyc(1, 3'd1, 4'b0001, 0);
    chk("rel_still_stall", 32'(stall_RO_DP), 32'd1);
    chk("stall_cnt2", stall_cycles, 32'd2);
    cyc(1, 3'd1, 4'b0, 0);
    chk("rel_cred1", 32'(credit[2:0]), 32'd1);
    chk("rel_disp", 32'(dispatch_sel), 32'b0001);
    chk("rel_nostall", 32'(stall_RO_DP), 32'd0);
    cyc(1, 3'd1, 4'b0, 0);
    chk("rel_cred0", 32'(credit[2:0]), 32'd0);
    chk("restall", 32'(stall_RO_DP), 32'd1);
    chk("stall_cnt3", stall_cycles, 32'd3);

    // Flush while stalled; release during flush is ignored
    cyc(0, 3'd1, 4'b0010, 1);
    chk("fl_stall", 32'(stall_RO_DP), 32'd0);
    chk("fl_flush_out", 32'(flush_RO_DP), 32'd1);
    chk("fl_disp", 32'(dispatch_valid), 32'd0);
    cyc(0, 3'd1, 4'b0, 0);
    chk("fl_cred", 32'(credit), CRED_ALL4);
    chk("fl_empty_disp", 32'(dispatch_valid), 32'd0);
    chk("fl_empty_stall", 32'(stall_RO_DP), 32'd0);
    chk("fl_err", 32'(err), 32'd0);
    chk("fl_stall_cnt", stall_cycles, 32'd4);

    // FU3 down to credit 2, then simultaneous dispatch and release
    cyc(1, 3'd0, 4'b0, 0);
    cyc(1, 3'd3, 4'b0, 0);
    chk("fu3_sel_a", 32'(dispatch_sel), 32'b0100);
    cyc(1, 3'd3, 4'b0, 0);
    chk("fu3_sel_b", 32'(dispatch_sel), 32'b0100);
    cyc(0, 3'd3, 4'b0100, 0);
    chk("fu3_cred2", 32'(credit[8:6]), 32'd2);
    chk("fu3_sel_c", 32'(dispatch_sel), 32'b0100);
    cyc(0, 3'd3, 4'b0010, 0);
    chk("fu3_net", 32'(credit[8:6]), 32'd2);
    chk("ovf_err_pre", 32'(err), 32'd0);
    cyc(0, 3'd0, 4'b0, 0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cred", 32'(credit), 32'h8A4);

    // Bubble then illegal FU type
    do_reset;
    #2;
    chk("rst2_err", 32'(err), 32'd0);
    cyc(1, 3'd0, 4'b0, 0);
    cyc(1, 3'd0, 4'b0, 0);
    chk("bub_disp", 32'(dispatch_valid), 32'd0);
    chk("bub_stall", 32'(stall_RO_DP), 32'd0);
    cyc(0, 3'd7, 4'b0, 0);
    chk("bub_err", 32'(err), 32'd0);
    chk("ill_disp", 32'(dispatch_valid), 32'd0);
    chk("ill_stall", 32'(stall_RO_DP), 32'd0);
    cyc(0, 3'd0, 4'b0, 0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_cred", 32'(credit), CRED_ALL4);

    // Asynchronous reset in the middle of a stall
    do_reset;
    cyc(1, 3'd0, 4'b0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 3'd4, 4'b0, 0);
    cyc(1, 3'd4, 4'b0, 0);
    cyc(1, 3'd4, 4'b0, 0);
    chk("ar_stall", 32'(stall_RO_DP), 32'd1);
    chk("ar_cnt", stall_cycles, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_stall_drop", 32'(stall_RO_DP), 32'd0);
    chk("ar_disp", 32'(dispatch_valid), 32'd0);
    chk("ar_cred", 32'(credit), CRED_ALL4);
    chk("ar_cnt0", stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    chk("ar_disp_edge", 32'(dispatch_valid), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_credit_ctrl.md
Name: dispatch_credit_ctrl

Overview:
Sequences the rename-to-dispatch pipeline register by generating its stall and flush controls. Routes the held instruction to one reservation station (RS) per functional-unit type. Tracks free RS slots with per-FU credit counters and holds the pipeline register while the target RS is full. Sits between the rename stage, the RO_DP register and the RS bank; the RS bank returns credits on issue.

Parameters:
NUM_FU, 4, number of FU types/RSs; FUType encodings 1..NUM_FU map to RS index 0..NUM_FU-1; FUType 0 = bubble/NOP.
RS_DEPTH, 4, entries per RS; initial and maximum credit per FU.
CW, $clog2(RS_DEPTH+1), credit counter width (localparam, derived).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  pipeline flush (branch mispredict / exception) from commit
valid_RN  in  1  rename stage presents an instruction this cycle
FUType_DP  in  3  FUType currently held in RO_DP register
rs_release  in  NUM_FU  one-hot-per-FU pulse: RS i freed one entry this cycle (may be multi-hot)
stall_RO_DP  out  1  drives RO_DP stall (hold contents)
flush_RO_DP  out  1  drives RO_DP flush (insert bubble)
stall_RN  out  1  back-pressure to rename/upstream
dispatch_valid  out  1  instruction in RO_DP written to an RS this cycle
dispatch_sel  out  NUM_FU  one-hot RS write enable
credit  out  NUM_FU*CW  packed credit counters, FU i at [i*CW +: CW]
stall_cycles  out  32  count of cycles with stall_RO_DP high
err  out  1  sticky error flag

Behaviour:
- Reset (async, rst high): valid_DP=0, every credit=RS_DEPTH, stall_cycles=0, err=0. All combinational outputs are 0 while valid_DP=0 and flush=0.
- valid_DP is an internal flag marking RO_DP occupancy. Next value:
  - flush: 0.
  - else stall_RO_DP: hold.
  - else: valid_RN.
- Decode: fu = FUType_DP. legal = 1<=fu<=NUM_FU. idx = fu-1.
- can_dispatch = valid_DP & legal & (credit[idx] != 0). Uses the registered credit only; no bypass from same-cycle rs_release.
- dispatch_valid = can_dispatch & ~flush. dispatch_sel = dispatch_valid ? (1<<idx) : 0.
- Bubble: valid_DP with fu==0 is consumed in one cycle with no dispatch and no credit change.
- Illegal FUType: valid_DP with fu>NUM_FU is consumed as a bubble and sets err.
- stall_RO_DP = valid_DP & legal & (credit[idx]==0) & ~flush.
  - flush must override stall here, because the RO_DP register gives stall priority over flush.
- stall_RN = stall_RO_DP. flush_RO_DP = flush (combinational, same cycle).
- Credit update per FU i, registered: credit_next = credit + rs_release[i] - (dispatch_sel[i]).
  - Release and dispatch on the same FU in one cycle: net unchanged.
- Release when credit==RS_DEPTH and no same-cycle dispatch on that FU: saturate at RS_DEPTH and set err.
- Flush: all credits reload to RS_DEPTH next cycle, since the RSs are cleared on flush. rs_release during a flush cycle is ignored.
- Latency:
  - Instruction latched into RO_DP at edge N (valid_RN=1, no stall) dispatches combinationally in cycle N+1 if credit>0.
  - That credit decrements at edge N+2.
  - A full pipeline sustains 1 dispatch/cycle.
- stall_cycles increments each cycle stall_RO_DP=1 and wraps 2^32-1 -> 0. It is not cleared by flush.
- err is sticky until rst.
- Reset mid-stall: all state returns to reset values immediately; no dispatch occurs on the reset cycle.

Test Plan:
- Reset, then 4 back-to-back FUType=1 instrs, no releases -> dispatch_sel=0001 on 4 consecutive cycles, credit[0]=0; 5th FUType=1 -> stall_RO_DP=stall_RN=1, stall_cycles counts up.
- From the previous state, pulse rs_release[0] once -> credit[0]=1 next edge, 5th instr dispatches the following cycle, credit[0]=0, stall drops.
- credit[0]=0 and FU0 instruction stalled, assert flush -> stall_RO_DP=0 and flush_RO_DP=1 same cycle, dispatch_valid=0; next cycle valid_DP=0, all credits=4.
- credit[2]=2, simultaneous dispatch FUType=3 and rs_release[2]=1 -> credit[2] stays 2; rs_release[1] with credit[1]=4 -> credit[1]=4, err=1.
- FUType_DP=0 then FUType_DP=7 (NUM_FU=4) with valid_DP -> no dispatch, no stall, credits unchanged; err set only by the 7.
- Assert rst asynchronously mid-stall (between edges) -> outputs drop to reset values before the next clk edge, credits=4, stall_cycles=0.
